// File: rtl/crtc_pkg.sv
// rtl/crtc_pkg.sv - register indices, reset defaults and vertical state encoding for the CRTC
package crtc_pkg;

  localparam logic [3:0] R_HTOT  = 4'd0;
  localparam logic [3:0] R_HDISP = 4'd1;
  localparam logic [3:0] R_HSPOS = 4'd2;
  localparam logic [3:0] R_SYNCW = 4'd3;
  localparam logic [3:0] R_VTOT  = 4'd4;
  localparam logic [3:0] R_VADJ  = 4'd5;
  localparam logic [3:0] R_VDISP = 4'd6;
  localparam logic [3:0] R_VSPOS = 4'd7;
  localparam logic [3:0] R_MAXRA = 4'd9;
  localparam logic [3:0] R_MA_H  = 4'd12;
  localparam logic [3:0] R_MA_L  = 4'd13;

  localparam logic [7:0] R1_RST  = 8'd40;
  localparam logic [7:0] R2_RST  = 8'd46;
  localparam logic [3:0] HSW_RST = 4'hE;
  localparam logic [3:0] VSW_RST = 4'h8;
  localparam logic [4:0] R5_RST  = 5'd0;
  localparam logic [6:0] R6_RST  = 7'd25;
  localparam logic [4:0] R9_RST  = 5'd7;
  localparam logic [5:0] R12_RST = 6'h30;
  localparam logic [7:0] R13_RST = 8'h00;

  typedef enum logic {
    DISP_ROWS = 1'b0,
    ADJUST    = 1'b1
  } vstate_t;

  typedef struct packed {
    logic [7:0] htot;
    logic [7:0] hdisp;
    logic [7:0] hspos;
    logic [3:0] hsw;
    logic [3:0] vsw;
    logic [6:0] vtot;
    logic [4:0] vadj;
    logic [6:0] vdisp;
    logic [6:0] vspos;
    logic [4:0] maxra;
    logic [5:0] ma_h;
    logic [7:0] ma_l;
  } crtc_regs_t;

endpackage

// File: rtl/crtc_timing_gen_if.sv
// rtl/crtc_timing_gen_if.sv - indexed register write port driven by the Z80 side
interface crtc_timing_gen_if;
  logic       WR;
  logic [3:0] ADDR;
  logic [7:0] DIN;

  modport master (output WR, ADDR, DIN);
  modport slave  (input  WR, ADDR, DIN);
endinterface

// File: rtl/crtc_regfile.sv
// rtl/crtc_regfile.sv - CRTC register storage with write decode and reset defaults
module crtc_regfile
  import crtc_pkg::*;
#(
  parameter int HTOT_RST  = 63,
  parameter int VTOT_RST  = 38,
  parameter int VSYNC_RST = 30
) (
  input  logic             CLK,
  input  logic             RESET_N,
  crtc_timing_gen_if.slave cpu,
  output crtc_regs_t       regs
);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs.htot  <= 8'(HTOT_RST);
      regs.hdisp <= R1_RST;
      regs.hspos <= R2_RST;
      regs.hsw   <= HSW_RST;
      regs.vsw   <= VSW_RST;
      regs.vtot  <= 7'(VTOT_RST);
      regs.vadj  <= R5_RST;
      regs.vdisp <= R6_RST;
      regs.vspos <= 7'(VSYNC_RST);
      regs.maxra <= R9_RST;
      regs.ma_h  <= R12_RST;
      regs.ma_l  <= R13_RST;
    end else if (cpu.WR) begin
      // Unlisted indices (8, 10, 11, 14, 15) fall through and are dropped.
      case (cpu.ADDR)
        R_HTOT:  regs.htot  <= cpu.DIN;
        R_HDISP: regs.hdisp <= cpu.DIN;
        R_HSPOS: regs.hspos <= cpu.DIN;
        R_SYNCW: begin
          regs.hsw <= cpu.DIN[3:0];
          regs.vsw <= cpu.DIN[7:4];
        end
        R_VTOT:  regs.vtot  <= cpu.DIN[6:0];
        R_VADJ:  regs.vadj  <= cpu.DIN[4:0];
        R_VDISP: regs.vdisp <= cpu.DIN[6:0];
        R_VSPOS: regs.vspos <= cpu.DIN[6:0];
        R_MAXRA: regs.maxra <= cpu.DIN[4:0];
        R_MA_H:  regs.ma_h  <= cpu.DIN[5:0];
        R_MA_L:  regs.ma_l  <= cpu.DIN;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/crtc_timing_gen.sv
// rtl/crtc_timing_gen.sv - 6845 type-0 style timing generator: counters, vertical FSM, raw syncs
module crtc_timing_gen
  import crtc_pkg::*;
#(
  parameter int HTOT_RST  = 63,
  parameter int VTOT_RST  = 38,
  parameter int VSYNC_RST = 30
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CE_1,
  crtc_timing_gen_if.slave cpu,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             DE,
  output logic [13:0]      MA,
  output logic [4:0]       RA
);

  crtc_regs_t r;

  crtc_regfile #(
    .HTOT_RST (HTOT_RST),
    .VTOT_RST (VTOT_RST),
    .VSYNC_RST(VSYNC_RST)
  ) u_regfile (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .cpu    (cpu),
    .regs   (r)
  );

  vstate_t     vstate, vstate_n;
  logic [7:0]  hcc, hcc_n;
  logic        hdisp, hdisp_n, vdisp, vdisp_n;
  logic [3:0]  hs_cnt, hs_cnt_n, vs_cnt, vs_cnt_n;
  logic [6:0]  vcc, vcc_n;
  logic [4:0]  ra, ra_n, adj, adj_n;
  logic [13:0] ma_row, ma_row_n;
  logic        hsync_n, vsync_n;
  logic        eol, row_start, frame_start;

  assign RA = ra;

  always_comb begin
    eol         = (hcc == r.htot);
    hcc_n       = eol ? 8'd0 : hcc + 8'd1;
    hdisp_n     = hdisp;
    hsync_n     = HSYNC;
    hs_cnt_n    = hs_cnt;
    vstate_n    = vstate;
    vcc_n       = vcc;
    ra_n        = ra;
    adj_n       = adj;
    ma_row_n    = ma_row;
    vdisp_n     = vdisp;
    vsync_n     = VSYNC;
    vs_cnt_n    = vs_cnt;
    row_start   = 1'b0;
    frame_start = 1'b0;

    // Clear wins over set so that R1=0 keeps the line blank.
    if (hcc_n == 8'd0)    hdisp_n = 1'b1;
    if (hcc_n == r.hdisp) hdisp_n = 1'b0;

    if (HSYNC) begin
      if (hs_cnt == 4'd0) hsync_n  = 1'b0;
      else                hs_cnt_n = hs_cnt - 4'd1;
    end else if (hcc_n == r.hspos && r.hsw != 4'd0) begin
      hsync_n  = 1'b1;
      hs_cnt_n = r.hsw - 4'd1;
    end

    if (eol) begin
      if (vstate == DISP_ROWS) begin
        if (ra != r.maxra) begin
          ra_n = ra + 5'd1;
        end else begin
          ra_n     = 5'd0;
          ma_row_n = ma_row + 14'(r.hdisp);
          if (vcc == r.vtot) begin
            if (r.vadj != 5'd0) begin
              vstate_n = ADJUST;
              adj_n    = 5'd0;
            end else begin
              frame_start = 1'b1;
            end
          end else begin
            vcc_n     = vcc + 7'd1;
            row_start = 1'b1;
          end
        end
      end else begin
        if (5'(adj + 5'd1) == r.vadj) begin
          frame_start = 1'b1;
        end else begin
          adj_n = adj + 5'd1;
          ra_n  = ra + 5'd1;
        end
      end

      if (frame_start) begin
        vstate_n  = DISP_ROWS;
        vcc_n     = 7'd0;
        ra_n      = 5'd0;
        vdisp_n   = 1'b1;
        ma_row_n  = {r.ma_h, r.ma_l};
        row_start = 1'b1;
      end

      if (row_start && vcc_n == r.vdisp) vdisp_n = 1'b0;

      // VSYNC width counts EOLs; a zero width field wraps to 15, i.e. 16 lines.
      if (VSYNC) begin
        if (vs_cnt == 4'd0) vsync_n  = 1'b0;
        else                vs_cnt_n = vs_cnt - 4'd1;
      end else if (row_start && vcc_n == r.vspos) begin
        vsync_n  = 1'b1;
        vs_cnt_n = r.vsw - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vstate <= DISP_ROWS;
      hcc    <= 8'd0;
      // Reset parks the beam at the top-left of a frame, inside the display window.
      hdisp  <= 1'b1;
      vdisp  <= 1'b1;
      hs_cnt <= 4'd0;
      vs_cnt <= 4'd0;
      vcc    <= 7'd0;
      ra     <= 5'd0;
      adj    <= 5'd0;
      ma_row <= 14'd0;
      HSYNC  <= 1'b0;
      VSYNC  <= 1'b0;
      DE     <= 1'b0;
      MA     <= 14'd0;
    end else if (CE_1) begin
      vstate <= vstate_n;
      hcc    <= hcc_n;
      hdisp  <= hdisp_n;
      vdisp  <= vdisp_n;
      hs_cnt <= hs_cnt_n;
      vs_cnt <= vs_cnt_n;
      vcc    <= vcc_n;
      ra     <= ra_n;
      adj    <= adj_n;
      ma_row <= ma_row_n;
      HSYNC  <= hsync_n;
      VSYNC  <= vsync_n;
      DE     <= hdisp_n & vdisp_n;
      MA     <= ma_row_n + 14'(hcc_n);
    end
  end

endmodule

// File: tb/tb_crtc_timing_gen.sv
// tb/tb_crtc_timing_gen.sv - directed scoreboard bench for crtc_timing_gen
module tb_crtc_timing_gen;
  import crtc_pkg::*;

  localparam int K_AT = 0, K_CNT = 1, K_RISE = 2, K_FALL = 3;
  localparam int S_HS = 0, S_VS = 1, S_DE = 2, S_MA = 3, S_RA = 4;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [13:0] ma;
    logic [4:0]  ra;
  } smp_t;

  typedef struct {
    string tag;
    int    kind;
    int    sel;
    int    a;
    int    b;
    int    want;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CE_1 = 1'b0;
  logic        HSYNC, VSYNC, DE;
  logic [13:0] MA;
  logic [4:0]  RA;

  crtc_timing_gen_if bus ();

  crtc_timing_gen #(.HTOT_RST(63), .VTOT_RST(38), .VSYNC_RST(30)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .CE_1   (CE_1),
    .cpu    (bus),
    .HSYNC  (HSYNC),
    .VSYNC  (VSYNC),
    .DE     (DE),
    .MA     (MA),
    .RA     (RA)
  );

  always #5 CLK = ~CLK;

  smp_t tr[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic int sig_at(int i, int sel);
    if (i < 0 || i >= tr.size()) return -1;
    case (sel)
      S_HS:    return int'(tr[i].hs);
      S_VS:    return int'(tr[i].vs);
      S_DE:    return int'(tr[i].de);
      S_MA:    return int'(tr[i].ma);
      default: return int'(tr[i].ra);
    endcase
  endfunction

  function automatic int measure(exp_t e);
    int r;
    r = -1;
    case (e.kind)
      K_AT: r = sig_at(e.a, e.sel);
      K_CNT: begin
        r = 0;
        for (int i = e.a; i < e.b; i++) r += sig_at(i, e.sel);
      end
      K_RISE: begin
        for (int i = (e.a < 1) ? 1 : e.a; i < tr.size(); i++)
          if (r < 0 && sig_at(i, e.sel) == 1 && sig_at(i - 1, e.sel) == 0) r = i;
      end
      default: begin
        for (int i = e.a; i < tr.size(); i++)
          if (r < 0 && sig_at(i, e.sel) == 0) r = i;
      end
    endcase
    return r;
  endfunction

  function automatic void expect_push(string tag, int kind, int sel, int a, int b, int want);
    exp_t e;
    e.tag = tag; e.kind = kind; e.sel = sel; e.a = a; e.b = b; e.want = want;
    exp_q.push_back(e);
  endfunction

  task automatic drain();
    exp_t e;
    int   obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = measure(e);
      n_cmp++;
      assert (obs === e.want) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.want);
      end
    end
  endtask

  task automatic sample();
    tr.push_back({HSYNC, VSYNC, DE, MA, RA});
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CE_1 = 1'b0; bus.WR = 1'b0; bus.ADDR = 4'd0; bus.DIN = 8'd0;
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.WR = 1'b1; bus.ADDR = a; bus.DIN = d;
    @(negedge CLK);
    bus.WR = 1'b0;
  endtask

  task automatic start_trace();
    tr.delete();
    sample();
    CE_1 = 1'b1;
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      @(negedge CLK);
      sample();
    end
  endtask

  // 16-char lines, 4-line rows, 6 rows: 24-line / 384-tick frames.
  task automatic load_small();
    wr(R_HTOT, 8'd15);  wr(R_HDISP, 8'd8);  wr(R_HSPOS, 8'd10);
    wr(R_SYNCW, 8'h23); wr(R_VTOT, 8'd5);   wr(R_VDISP, 8'd3);
    wr(R_VSPOS, 8'd4);  wr(R_MAXRA, 8'd3);  wr(R_MA_H, 8'h00);
    wr(R_MA_L, 8'h00);  wr(4'd8, 8'hFF);    wr(4'd15, 8'hFF);
  endtask

  initial begin
    bus.WR = 1'b0; bus.ADDR = 4'd0; bus.DIN = 8'd0;

    // Reset defaults over two full 312-line frames.
    do_reset();
    start_trace();
    expect_push("rst_ma", K_AT, S_MA, 0, 0, 0);
    expect_push("rst_hs", K_AT, S_HS, 0, 0, 0);
    expect_push("rst_de", K_AT, S_DE, 0, 0, 0);
    expect_push("first_ce_ma", K_AT, S_MA, 1, 0, 1);
    expect_push("hs_rise0", K_RISE, S_HS, 0, 0, 46);
    expect_push("hs_rise1", K_RISE, S_HS, 47, 0, 110);
    expect_push("hs_width", K_CNT, S_HS, 0, 64, 14);
    expect_push("vs_rise0", K_RISE, S_VS, 0, 0, 240 * 64);
    expect_push("vs_lines", K_CNT, S_VS, 0, 312 * 64, 8 * 64);
    expect_push("frame_ma", K_AT, S_MA, 312 * 64, 0, 'h3000);
    expect_push("frame_ra", K_AT, S_RA, 312 * 64, 0, 0);
    expect_push("row0_ra7", K_AT, S_RA, 312 * 64 + 7 * 64, 0, 7);
    expect_push("vs_rise1", K_RISE, S_VS, 240 * 64 + 1, 0, 312 * 64 + 240 * 64);
    expect_push("de_line", K_CNT, S_DE, 312 * 64, 313 * 64, 40);
    expect_push("de_frame", K_CNT, S_DE, 312 * 64, 624 * 64, 8000);
    capture(624 * 64 + 4);
    drain();

    // Vertical adjust of 2 lines.
    do_reset();
    load_small();
    wr(R_VADJ, 8'd2);
    start_trace();
    expect_push("adj_ra0", K_AT, S_RA, 384 + 3, 0, 0);
    expect_push("adj_ra1", K_AT, S_RA, 400 + 2, 0, 1);
    expect_push("adj_ma_hold", K_AT, S_MA, 400 + 2, 0, 50);
    expect_push("adj_de", K_CNT, S_DE, 384, 416, 0);
    expect_push("adj_newframe_ra", K_AT, S_RA, 416, 0, 0);
    expect_push("adj_vs_rise0", K_RISE, S_VS, 0, 0, 256);
    expect_push("adj_vs_rise1", K_RISE, S_VS, 257, 0, 672);
    expect_push("adj_de_frame", K_CNT, S_DE, 416, 832, 96);
    expect_push("small_hs_w3", K_CNT, S_HS, 416, 432, 3);
    capture(840);
    drain();

    // Sync widths of zero: no HSYNC, 16-line VSYNC.
    do_reset();
    load_small();
    wr(R_SYNCW, 8'h00);
    start_trace();
    expect_push("w0_no_hs", K_CNT, S_HS, 0, 700, 0);
    expect_push("w0_vs_rise", K_RISE, S_VS, 0, 0, 256);
    expect_push("w0_vs_fall", K_FALL, S_VS, 256, 0, 512);
    expect_push("w0_vs_rise1", K_RISE, S_VS, 257, 0, 640);
    capture(700);
    drain();

    do_reset();
    load_small();
    wr(R_SYNCW, 8'h05);
    start_trace();
    expect_push("w5_hs_rise", K_RISE, S_HS, 0, 0, 10);
    expect_push("w5_hs_fall", K_FALL, S_HS, 10, 0, 15);
    expect_push("w5_hs_cnt", K_CNT, S_HS, 0, 16, 5);
    capture(20);
    drain();

    // Start address and row stride.
    do_reset();
    load_small();
    wr(R_MA_H, 8'h0C); wr(R_MA_L, 8'h10); wr(R_HDISP, 8'd40);
    start_trace();
    expect_push("ma_first", K_AT, S_MA, 384, 0, 'h0C10);
    expect_push("ma_row1", K_AT, S_MA, 448, 0, 'h0C38);
    expect_push("ma_row1_c1", K_AT, S_MA, 449, 0, 'h0C39);
    expect_push("ma_row1_ra", K_AT, S_RA, 448, 0, 0);
    capture(460);
    drain();

    do_reset();
    load_small();
    wr(R_MA_H, 8'h3F); wr(R_MA_L, 8'hF0);
    start_trace();
    expect_push("wrap_first", K_AT, S_MA, 384, 0, 'h3FF0);
    expect_push("wrap_top0", K_AT, S_MA, 399, 0, 'h3FFF);
    expect_push("wrap_row1", K_AT, S_MA, 448, 0, 'h3FF8);
    expect_push("wrap_top1", K_AT, S_MA, 455, 0, 'h3FFF);
    expect_push("wrap_zero", K_AT, S_MA, 456, 0, 0);
    capture(460);
    drain();

    // Shrink R0 below the running hcc: run to 255, silent wrap, then 21-char lines.
    do_reset();
    start_trace();
    capture(40);
    CE_1 = 1'b0;
    wr(R_HTOT, 8'd20);
    CE_1 = 1'b1;
    expect_push("r0_hcc40", K_AT, S_MA, 40, 0, 40);
    expect_push("r0_hcc255", K_AT, S_MA, 255, 0, 255);
    expect_push("r0_wrap_ma", K_AT, S_MA, 256, 0, 0);
    expect_push("r0_wrap_noeol", K_AT, S_RA, 256, 0, 0);
    expect_push("r0_hcc20", K_AT, S_MA, 276, 0, 20);
    expect_push("r0_eol1", K_AT, S_RA, 277, 0, 1);
    expect_push("r0_pre_eol2", K_AT, S_RA, 297, 0, 1);
    expect_push("r0_eol2", K_AT, S_RA, 298, 0, 2);
    capture(260);
    drain();

    // Asynchronous reset mid-frame with both syncs active.
    do_reset();
    load_small();
    start_trace();
    capture(267);
    expect_push("pre_rst_hs", K_AT, S_HS, 267, 0, 1);
    expect_push("pre_rst_vs", K_AT, S_VS, 267, 0, 1);
    RESET_N = 1'b0;
    #1;
    sample();
    expect_push("async_hs", K_AT, S_HS, 268, 0, 0);
    expect_push("async_vs", K_AT, S_VS, 268, 0, 0);
    expect_push("async_de", K_AT, S_DE, 268, 0, 0);
    expect_push("async_ma", K_AT, S_MA, 268, 0, 0);
    expect_push("async_ra", K_AT, S_RA, 268, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    expect_push("post_rst_hcc1", K_AT, S_MA, 269, 0, 1);
    expect_push("post_rst_ra", K_AT, S_RA, 269, 0, 0);
    expect_push("post_rst_hs45", K_AT, S_HS, 313, 0, 0);
    expect_push("post_rst_hs46", K_AT, S_HS, 314, 0, 1);
    expect_push("post_rst_hsw", K_CNT, S_HS, 269, 332, 14);
    capture(70);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
